// File: rtl/controle_varredura_pwm_pkg.sv
// Shared types and constants for the PWM sweep sequencer.
package controle_varredura_pwm_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned LARG_W = 2;
  localparam int unsigned EST_W  = 3;

  localparam logic [LARG_W-1:0] POS_MIN = 2'd0;
  localparam logic [LARG_W-1:0] POS_MAX = 2'd3;

  // Sweep direction.
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  // FSM state codes; the numeric values are visible on estado_db.
  typedef enum logic [EST_W-1:0] {
    INICIAL = 3'd0,
    PREPARA = 3'd1,
    ESPERA  = 3'd2,
    MEDE    = 3'd3,
    AVANCA  = 3'd4,
    FIM     = 3'd5
  } estado_t;

endpackage

// File: rtl/controle_varredura_pwm_contador_dwell.sv
// Dwell counter: counts cycles while enabled and flags the last dwell cycle.
module contador_dwell
  import controle_varredura_pwm_pkg::*;
#(
  parameter int unsigned M = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim_contagem
);

  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(M - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: synchronous clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the final cycle of a dwell, decoded from the count register.
  assign fim_contagem = (cnt_q >= LIMITE);

endmodule

// File: rtl/controle_varredura_pwm.sv
// Ping-pong sweep sequencer for circuito_pwm: 0,1,2,3,2,1,0 with a dwell and
// a measurement strobe at each position; single or continuous sweeps.
module controle_varredura_pwm
  import controle_varredura_pwm_pkg::*;
#(
  parameter int unsigned TEMPO_DWELL = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              parar,
  input  logic              continuo,
  output logic [LARG_W-1:0] largura,
  output logic              ativo,
  output logic              medir,
  output logic              fim,
  output logic [EST_W-1:0]  estado_db
);

  estado_t           estado_q, estado_d;
  logic [LARG_W-1:0] largura_q, largura_d;
  dir_t              dir_q, dir_d;
  logic              modo_q, modo_d;
  logic              ativo_q, ativo_d;
  logic              medir_q, medir_d;
  logic              fim_q, fim_d;
  logic [EST_W-1:0]  estado_db_q, estado_db_d;

  logic zera;
  logic conta;
  logic fim_contagem;

  contador_dwell #(
    .M (TEMPO_DWELL)
  ) u_contador_dwell (
    .clock        (clock),
    .reset        (reset),
    .zera         (zera),
    .conta        (conta),
    .fim_contagem (fim_contagem)
  );

  // Next-state, position/direction update and output decode.
  always_comb begin
    estado_d  = estado_q;
    largura_d = largura_q;
    dir_d     = dir_q;
    modo_d    = modo_q;
    zera      = 1'b1;
    conta     = 1'b0;

    if (estado_q != INICIAL && parar) begin
      // Abort beats every other transition, including entry to MEDE/FIM.
      estado_d  = INICIAL;
      largura_d = POS_MIN;
      dir_d     = UP;
    end else begin
      case (estado_q)
        INICIAL: begin
          largura_d = POS_MIN;
          dir_d     = UP;
          if (iniciar && !parar) begin
            estado_d = PREPARA;
            modo_d   = continuo;
          end
        end
        PREPARA: begin
          largura_d = POS_MIN;
          dir_d     = UP;
          estado_d  = ESPERA;
        end
        ESPERA: begin
          if (fim_contagem) begin
            estado_d = MEDE;
          end else begin
            zera  = 1'b0;
            conta = 1'b1;
          end
        end
        MEDE: begin
          estado_d = AVANCA;
        end
        AVANCA: begin
          if (dir_q == UP) begin
            estado_d = ESPERA;
            if (largura_q < POS_MAX) begin
              largura_d = largura_q + LARG_W'(1);
            end else begin
              dir_d     = DOWN;
              largura_d = POS_MAX - LARG_W'(1);
            end
          end else if (largura_q > POS_MIN) begin
            estado_d  = ESPERA;
            largura_d = largura_q - LARG_W'(1);
          end else begin
            estado_d = FIM;
          end
        end
        FIM: begin
          estado_d = modo_q ? PREPARA : INICIAL;
        end
        default: begin
          estado_d  = INICIAL;
          largura_d = POS_MIN;
          dir_d     = UP;
        end
      endcase
    end

    ativo_d     = (estado_d != INICIAL);
    medir_d     = (estado_d == MEDE);
    fim_d       = (estado_d == FIM);
    estado_db_d = EST_W'(estado_d);
  end

  // State, position and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= INICIAL;
      largura_q   <= POS_MIN;
      dir_q       <= UP;
      modo_q      <= 1'b0;
      ativo_q     <= 1'b0;
      medir_q     <= 1'b0;
      fim_q       <= 1'b0;
      estado_db_q <= '0;
    end else begin
      estado_q    <= estado_d;
      largura_q   <= largura_d;
      dir_q       <= dir_d;
      modo_q      <= modo_d;
      ativo_q     <= ativo_d;
      medir_q     <= medir_d;
      fim_q       <= fim_d;
      estado_db_q <= estado_db_d;
    end
  end

  assign largura   = largura_q;
  assign ativo     = ativo_q;
  assign medir     = medir_q;
  assign fim       = fim_q;
  assign estado_db = estado_db_q;

endmodule

// File: tb/tb_controle_varredura_pwm.sv
// Directed bench for controle_varredura_pwm with a queue scoreboard.
// Observed/expected vectors are packed as {largura, medir, fim, ativo, estado}.
module tb_controle_varredura_pwm;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       parar;
  logic       continuo;

  logic [1:0] larg4, larg1;
  logic       ativo4, ativo1;
  logic       medir4, medir1;
  logic       fim4, fim1;
  logic [2:0] est4, est1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] q4[$];
  logic [7:0] q1[$];

  controle_varredura_pwm #(.TEMPO_DWELL(4)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .parar     (parar),
    .continuo  (continuo),
    .largura   (larg4),
    .ativo     (ativo4),
    .medir     (medir4),
    .fim       (fim4),
    .estado_db (est4)
  );

  controle_varredura_pwm #(.TEMPO_DWELL(1)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .parar     (parar),
    .continuo  (continuo),
    .largura   (larg1),
    .ativo     (ativo1),
    .medir     (medir1),
    .fim       (fim1),
    .estado_db (est1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  wire [7:0] obs4 = {larg4, medir4, fim4, ativo4, est4};
  wire [7:0] obs1 = {larg1, medir1, fim1, ativo1, est1};

  function automatic logic [1:0] pos_of(int k);
    case (k)
      0: return 2'd0;
      1: return 2'd1;
      2: return 2'd2;
      3: return 2'd3;
      4: return 2'd2;
      5: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Expected outputs in cycle n, where iniciar was sampled at the end of cycle 0.
  function automatic logic [7:0] exp_at(int n, int t, bit cont, int abort_at);
    int fimc;
    int m;
    int k;
    int r;
    logic [1:0] lg;
    logic [2:0] st;
    logic md;
    logic fm;
    fimc = 7 * (t + 2) + 2;
    m    = n;
    lg   = 2'd0;
    md   = 1'b0;
    fm   = 1'b0;
    if (abort_at >= 0 && n > abort_at) return 8'h00;
    if (m <= 0) return 8'h00;
    if (cont) begin
      while (m > fimc) m = m - fimc;
    end else if (m > fimc) begin
      return 8'h00;
    end
    if (m == 1) begin
      st = 3'd1;
    end else if (m == fimc) begin
      st = 3'd5;
      fm = 1'b1;
    end else begin
      k  = (m - 2) / (t + 2);
      r  = (m - 2) % (t + 2);
      lg = pos_of(k);
      if (r < t) st = 3'd2;
      else if (r == t) begin
        st = 3'd3;
        md = 1'b1;
      end else st = 3'd4;
    end
    return {lg, md, fm, 1'b1, st};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // One sweep run from INICIAL; optional abort and mid-sweep input disturbances.
  task automatic run(input string tag, input bit cont, input int abort_at,
                     input int ncyc, input bit chk1, input bit perturb);
    cyc      = 0;
    continuo = cont;
    iniciar  = 1'b1;
    parar    = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      q4.push_back(exp_at(n, 4, cont, abort_at));
      if (chk1) q1.push_back(exp_at(n, 1, cont, abort_at));
      step();
      iniciar = perturb && (n == 20);
      if (perturb) continuo = (n >= 10 && n < 30) ? ~cont : cont;
      parar = (n == abort_at);
      check({tag, "_t4"}, obs4, q4.pop_front());
      if (chk1) check({tag, "_t1"}, obs1, q1.pop_front());
    end
    iniciar  = 1'b0;
    parar    = 1'b0;
    continuo = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    iniciar  = 1'b0;
    parar    = 1'b0;
    continuo = 1'b0;

    // Reset state, before any clock edge.
    #3;
    q4.push_back(8'h00);
    q1.push_back(8'h00);
    check("reset_t4", obs4, q4.pop_front());
    check("reset_t1", obs1, q1.pop_front());
    step();
    step();
    reset = 1'b0;
    step();

    // Single sweep; mid-sweep iniciar and continuo changes must be ignored.
    run("single", 1'b0, -1, 50, 1'b1, 1'b1);

    // Continuous sweep stopped by parar at cycle 60.
    run("contin", 1'b1, 60, 66, 1'b0, 1'b0);

    // parar sampled on the edge that would enter MEDE.
    run("abort_mede", 1'b0, 5, 10, 1'b0, 1'b0);

    // parar sampled on the edge that would enter FIM.
    run("abort_fim", 1'b0, 43, 48, 1'b0, 1'b0);

    // iniciar with parar in INICIAL: parar wins.
    cyc     = 0;
    iniciar = 1'b1;
    parar   = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      q4.push_back(8'h00);
      step();
      check("ini_and_parar", obs4, q4.pop_front());
    end
    iniciar = 1'b0;
    parar   = 1'b0;
    step();

    // Async reset between edges while dwelling at largura = 3.
    cyc      = 0;
    continuo = 1'b0;
    iniciar  = 1'b1;
    for (int n = 1; n <= 21; n++) begin
      q4.push_back(exp_at(n, 4, 1'b0, -1));
      step();
      iniciar = 1'b0;
      check("pre_areset", obs4, q4.pop_front());
    end
    #2;
    reset = 1'b1;
    #1;
    q4.push_back(8'h00);
    q1.push_back(8'h00);
    check("areset_t4", obs4, q4.pop_front());
    check("areset_t1", obs1, q1.pop_front());
    #2;
    reset = 1'b0;

    // Restart after reset begins again at position 0.
    run("restart", 1'b0, -1, 46, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
